// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM encoding,
// parity mode encodings and the oversample tick divider calculation.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StStart  = 3'd1;
  localparam state_t StData   = 3'd2;
  localparam state_t StParity = 3'd3;
  localparam state_t StStop   = 3'd4;

  localparam int unsigned ParityNone = 0;
  localparam int unsigned ParityEven = 1;
  localparam int unsigned ParityOdd  = 2;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned bit_rate,
                                           input int unsigned oversample);
    return clk_hz / (bit_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: oversample tick divider, 2-flop line
// synchroniser, falling-edge detector and 3-sample majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BIT_RATE   = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic rxd,
  output logic os_tick,
  output logic fall,
  output logic maj
);

  localparam int unsigned Div  = calc_div(CLK_HZ, BIT_RATE, OVERSAMPLE);
  localparam int unsigned DivW = (Div > 2) ? $clog2(Div) : 1;

  logic [DivW-1:0] div_q;
  logic [1:0]      sync_q;
  logic [1:0]      hist_q;
  logic            line;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      sync_q <= 2'b11;
      hist_q <= 2'b11;
    end else begin
      div_q  <= os_tick ? '0 : div_q + 1'b1;
      sync_q <= {sync_q[0], rxd};
      if (os_tick) begin
        hist_q <= {hist_q[0], line};
      end
    end
  end

  assign os_tick = (div_q == DivW'(Div - 1));
  assign line    = sync_q[1];
  assign fall    = os_tick & hist_q[0] & ~line;
  // Valid on the tick that takes the third sample: two history samples plus the current line.
  assign maj     = (hist_q[1] & hist_q[0]) | (hist_q[1] & line) | (hist_q[0] & line);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: frame FSM plus one-word output register with
// ready/valid handshake. Parity support is built only when UART_RX_PARITY_EN is defined.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    rx_frame_err,
  output logic                    rx_parity_err,
  output logic                    rx_break,
  output logic                    rx_overrun,
  output logic                    busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(PAYLOAD_BITS);
  localparam logic [TickW-1:0] MajIdx  = TickW'(OVERSAMPLE / 2 + 1);
  localparam logic [TickW-1:0] EndIdx  = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  LastBit = BitW'(PAYLOAD_BITS - 1);
  localparam logic             LastStop = 1'(STOP_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam bit HasParity = (PARITY_MODE != ParityNone);
`else
  localparam bit HasParity = 1'b0;
`endif

  logic os_tick, fall, maj;

  uart_rx_sampler #(
    .CLK_HZ    (CLK_HZ),
    .BIT_RATE  (BIT_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk    (clk),
    .reset  (reset),
    .rxd    (uart_rxd),
    .os_tick(os_tick),
    .fall   (fall),
    .maj    (maj)
  );

  state_t                  state_q, state_d;
  logic [TickW-1:0]        tick_q, tick_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic                    stop_q, stop_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    stop_err_q, stop_err_d;
  logic                    first_zero_q, first_zero_d;
  logic                    at_maj, at_end, complete;
  logic                    first_zero, par_zero, par_err, brk, frame_err;
`ifdef UART_RX_PARITY_EN
  logic                    par_bit_q, par_bit_d;

  assign par_zero = HasParity ? ~par_bit_q : 1'b1;
  assign par_err  = HasParity & (^shift_q ^ par_bit_q ^ (PARITY_MODE == ParityOdd));
`else
  assign par_zero = 1'b1;
  assign par_err  = 1'b0;
`endif

  assign at_maj     = (tick_q == MajIdx);
  assign at_end     = (tick_q == EndIdx);
  // Only meaningful on the completing tick, where maj is the last stop bit.
  assign first_zero = (stop_q == 1'b0) ? ~maj : first_zero_q;
  assign brk        = (shift_q == '0) & first_zero & par_zero;
  assign frame_err  = stop_err_q | ~maj | brk;
  assign busy       = (state_q != StIdle);

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    stop_d       = stop_q;
    shift_d      = shift_q;
    stop_err_d   = stop_err_q;
    first_zero_d = first_zero_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
`endif
    complete     = 1'b0;
    if (!uart_rx_en) begin
      state_d = StIdle;
      tick_d  = '0;
      bit_d   = '0;
      stop_d  = 1'b0;
    end else if (os_tick) begin
      tick_d = at_end ? '0 : tick_q + 1'b1;
      case (state_q)
        StIdle: begin
          tick_d = '0;
          // The detecting tick is sample 0 of the start bit.
          if (fall) begin
            state_d = StStart;
            tick_d  = TickW'(1);
          end
        end
        StStart: begin
          if (at_maj && maj) begin
            state_d = StIdle;
            tick_d  = '0;
          end else if (at_end) begin
            state_d      = StData;
            bit_d        = '0;
            stop_d       = 1'b0;
            stop_err_d   = 1'b0;
            first_zero_d = 1'b0;
          end
        end
        StData: begin
          if (at_maj) begin
            shift_d = {maj, shift_q[PAYLOAD_BITS-1:1]};
          end
          if (at_end) begin
            if (bit_q == LastBit) begin
              state_d = HasParity ? StParity : StStop;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (at_maj) begin
            par_bit_d = maj;
          end
          if (at_end) begin
            state_d = StStop;
          end
        end
`endif
        StStop: begin
          if (at_maj) begin
            if (stop_q == LastStop) begin
              complete = 1'b1;
              state_d  = StIdle;
              tick_d   = '0;
            end else begin
              stop_err_d   = stop_err_q | ~maj;
              first_zero_d = ~maj;
            end
          end else if (at_end) begin
            stop_d = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          tick_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shift_q      <= '0;
      stop_err_q   <= 1'b0;
      first_zero_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      shift_q      <= shift_d;
      stop_err_q   <= stop_err_d;
      first_zero_q <= first_zero_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
`endif
    end
  end

  // A completion that finds an unaccepted word is dropped and flagged as overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_break      <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (complete) begin
      if (rx_valid && !rx_ready) begin
        rx_overrun <= 1'b1;
      end else begin
        rx_data       <= shift_q;
        rx_frame_err  <= frame_err;
        rx_parity_err <= par_err;
        rx_break      <= brk;
        rx_valid      <= 1'b1;
        rx_overrun    <= 1'b0;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os at 50 MHz / 115200 baud / 16x oversampling.
module tb_uart_rx_os;

  localparam int unsigned BitClks = 27 * 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned Pm    = 1;
  localparam bit          ParOn = 1'b1;
`else
  localparam int unsigned Pm    = 0;
  localparam bit          ParOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_en = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_parity_err, rx_break, rx_overrun, busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       brk;
    logic       ovr;
  } word_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       fe;
    logic       brk;
  } vec_t;

  word_t got_q[$];
  vec_t  vecs[5];

  always #10 clk = ~clk;

  uart_rx_os #(
    .CLK_HZ      (50_000_000),
    .BIT_RATE    (115200),
    .OVERSAMPLE  (16),
    .PAYLOAD_BITS(8),
    .STOP_BITS   (1),
    .PARITY_MODE (Pm)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rxd     (uart_rxd),
    .uart_rx_en   (uart_rx_en),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_break     (rx_break),
    .rx_overrun   (rx_overrun),
    .busy         (busy)
  );

  function automatic word_t mk(input logic [7:0] d, input logic fe, input logic pe,
                               input logic brk, input logic ovr);
    word_t w;
    w.data = d;
    w.fe   = fe;
    w.pe   = pe;
    w.brk  = brk;
    w.ovr  = ovr;
    return w;
  endfunction

  // Reference: a frame with correct parity is a break when the whole payload and the
  // stop bit are low; a low stop bit or a break is a framing error.
  function automatic word_t model(input logic [7:0] d, input logic stop);
    logic b;
    b = (d == 8'h00) && !stop;
    return mk(d, !stop || b, 1'b0, b, 1'b0);
  endfunction

  always @(negedge clk) begin
    if (!reset && rx_valid && rx_ready) begin
      got_q.push_back(mk(rx_data, rx_frame_err, rx_parity_err, rx_break, rx_overrun));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line_for(input logic v, input int bits);
    uart_rxd = v;
    clks(bits * BitClks);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    line_for(1'b0, 1);
    for (int i = 0; i < 8; i++) line_for(d[i], 1);
    if (ParOn) line_for(par, 1);
    line_for(stop, 1);
    line_for(1'b1, 1);
  endtask

  task automatic check_word(input string name, input word_t exp);
    word_t w;
    int    t;
    t = 0;
    while (got_q.size() < 1 && t < 2000) begin
      clks(1);
      t++;
    end
    chk({name, "_count"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      chk({name, "_data"}, w.data, exp.data);
      chk({name, "_fe"}, w.fe, exp.fe);
      chk({name, "_pe"}, w.pe, exp.pe);
      chk({name, "_brk"}, w.brk, exp.brk);
      chk({name, "_ovr"}, w.ovr, exp.ovr);
    end
    got_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;

    vecs[0] = '{d: 8'hA5, stop: 1'b1, fe: 1'b0, brk: 1'b0};
    vecs[1] = '{d: 8'h3C, stop: 1'b0, fe: 1'b1, brk: 1'b0};
    vecs[2] = '{d: 8'h00, stop: 1'b0, fe: 1'b1, brk: 1'b1};
    vecs[3] = '{d: 8'hFF, stop: 1'b1, fe: 1'b0, brk: 1'b0};
    vecs[4] = '{d: 8'h80, stop: 1'b1, fe: 1'b0, brk: 1'b0};

    // Reset state
    clks(5);
    chk("rst_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_fe", rx_frame_err, 0);
    chk("rst_ovr", rx_overrun, 0);
    reset      = 1'b0;
    uart_rx_en = 1'b1;
    rx_ready   = 1'b1;
    clks(50);

    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].d, ^vecs[i].d, vecs[i].stop);
      check_word($sformatf("vec%0d", i), mk(vecs[i].d, vecs[i].fe, 1'b0, vecs[i].brk, 1'b0));
      chk($sformatf("vec%0d_valid_low", i), rx_valid, 0);
    end

    // Short low glitch of three os_ticks
    uart_rxd = 1'b0;
    clks(60);
    chk("glitch_busy_hi", busy, 1);
    clks(21);
    uart_rxd = 1'b1;
    clks(BitClks - 81);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_none", got_q.size(), 0);

    // Long break, then a normal frame
    line_for(1'b0, 12);
    line_for(1'b1, 1);
    check_word("break", mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
    send_frame(8'h55, ^8'h55, 1'b1);
    check_word("after_break", mk(8'h55, 1'b0, 1'b0, 1'b0, 1'b0));

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h11, ^8'h11, 1'b1);
    chk("ovr_first_valid", rx_valid, 1);
    chk("ovr_first_flag", rx_overrun, 0);
    send_frame(8'h22, ^8'h22, 1'b1);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_flag", rx_overrun, 1);
    rx_ready = 1'b1;
    clks(1);
    rx_ready = 1'b0;
    clks(2);
    chk("ovr_valid_cleared", rx_valid, 0);
    chk("ovr_flag_cleared", rx_overrun, 0);
    chk("ovr_accepted", got_q.size(), 1);
    if (got_q.size() > 0) chk("ovr_accepted_data", got_q[0].data, 8'h11);
    got_q.delete();
    rx_ready = 1'b1;

    // Receive enable dropped mid-frame
    uart_rxd = 1'b0;
    clks(3 * BitClks);
    chk("en_busy_hi", busy, 1);
    uart_rx_en = 1'b0;
    clks(2);
    chk("en_busy_lo", busy, 0);
    uart_rx_en = 1'b1;
    clks(6 * BitClks);
    line_for(1'b1, 2);
    chk("en_none", got_q.size(), 0);

    // Reset asserted mid-frame
    line_for(1'b0, 1);
    line_for(1'b1, 2);
    chk("rstmid_busy_hi", busy, 1);
    reset = 1'b1;
    clks(3);
    chk("rstmid_busy_lo", busy, 0);
    reset = 1'b0;
    clks(8 * BitClks);
    chk("rstmid_none", got_q.size(), 0);

    // Randomized frames against the reference model
    for (int i = 0; i < 4; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, ^d, stop);
      check_word($sformatf("rand%0d", i), model(d, stop));
    end

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    check_word("par_bad", mk(8'h07, 1'b0, 1'b1, 1'b0, 1'b0));
    send_frame(8'h07, 1'b1, 1'b1);
    check_word("par_good", mk(8'h07, 1'b0, 1'b0, 1'b0, 1'b0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 115200, line rate in bits/s.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, samples per bit; even, 8..32.
REQ-004 SHALL have parameter PAYLOAD_BITS, default 8, data bits per frame; 5..9.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame; 1 or 2.
REQ-006 SHALL have parameter PARITY_MODE, default 0, parity type: 0 none, 1 even, 2 odd; used only when UART_RX_PARITY_EN is defined.
REQ-007 SHALL have ports: clk in 1, the single system clock; reset in 1, synchronous, active-high.
REQ-008 SHALL have ports: uart_rxd in 1, asynchronous serial line; uart_rx_en in 1, receive enable.
REQ-009 SHALL have ports: rx_data out PAYLOAD_BITS, received word; rx_valid out 1, word available; rx_ready in 1, consumer accepts.
REQ-010 SHALL have ports: rx_frame_err, rx_parity_err, rx_break, rx_overrun, all out 1, status flags of the held word; busy out 1, frame in progress.

Function
REQ-011 SHALL generate a one-cycle os_tick every DIV = CLK_HZ/(BIT_RATE*OVERSAMPLE) clocks, using integer floor, with DIV >= 2.
REQ-012 SHALL synchronise uart_rxd through 2 flops reset to 1, and SHALL sample the synchronised line only on os_tick.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; busy=1 in every state except IDLE.
REQ-014 IDLE->START SHALL occur only on a falling edge between consecutive os_tick samples (previous 1, current 0); a line held low SHALL NOT retrigger.
REQ-015 Bit value SHALL be the majority of samples at tick indices OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 within the bit.
REQ-016 A start-bit majority of 1 SHALL be treated as a glitch: return to IDLE, no output.
REQ-017 DATA SHALL shift in PAYLOAD_BITS bits LSB first, OVERSAMPLE ticks per bit, then enter PARITY (if enabled) or STOP.
REQ-018 STOP SHALL check STOP_BITS bits; any 0 sets frame_err for the frame.
REQ-019 The frame SHALL complete at the majority point of the last stop bit, and the FSM SHALL enter IDLE on the next cycle.
REQ-020 Break SHALL be flagged when all data bits, the parity bit (if any) and the first stop bit are 0; a break also sets frame_err.
REQ-021 On completion, rx_data and rx_frame_err/rx_parity_err/rx_break SHALL load and rx_valid SHALL rise 1 cycle after the completing os_tick.
REQ-022 rx_valid SHALL stay high and the held word and flags SHALL stay stable until a cycle with rx_valid && rx_ready.
REQ-023 Completion while rx_valid=1 and rx_ready=0: the new frame SHALL be dropped, the held word SHALL be kept, and rx_overrun SHALL be set.
REQ-024 rx_overrun SHALL clear on the next accepted transfer.
REQ-025 Completion in the same cycle as an accepted transfer SHALL load the new word with rx_valid kept at 1 and SHALL NOT set overrun.
REQ-026 uart_rx_en=0 SHALL force the FSM to IDLE next cycle and discard any partial frame; the output register SHALL be unaffected.

Reset
REQ-027 reset SHALL put the FSM in IDLE, zero all counters, set the synchroniser and edge history to 1, set rx_data=0, and clear rx_valid, all flags and busy.
REQ-028 reset asserted mid-frame SHALL abort the frame with no output; the first falling edge after reset deasserts SHALL start a new frame.

Configuration
REQ-029 With macro UART_RX_PARITY_EN defined, the PARITY state and parity check (per PARITY_MODE) SHALL be compiled in; a mismatch sets rx_parity_err.
REQ-030 Without UART_RX_PARITY_EN, the PARITY state SHALL be absent, PARITY_MODE ignored, and rx_parity_err tied to 0.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum, the PARITY_MODE encodings, and a function computing DIV.
REQ-032 Sub-module uart_rx_sampler SHALL contain the tick divider, the synchroniser, the edge detector and 3-sample majority; uart_rx_os holds the FSM and output register.

Verification (CLK_HZ=50e6, BIT_RATE=115200, OVERSAMPLE=16, DIV=27)
REQ-033 Frame 0xA5 8N1 with rx_ready=1 -> one-cycle rx_valid, rx_data=0xA5, all flags 0.
REQ-034 Low pulse of 3 os_ticks -> no rx_valid, FSM back in IDLE, busy low within 16 ticks.
REQ-035 Frame 0x3C with stop bit 0 -> rx_data=0x3C, rx_frame_err=1, rx_break=0.
REQ-036 Line low for 12 bit times, then high -> exactly one word: rx_data=0x00, rx_break=1, rx_frame_err=1; the next frame 0x55 is received normally.
REQ-037 Frames 0x11 then 0x22 with rx_ready=0 -> held rx_data=0x11, rx_overrun=1; one rx_ready pulse -> rx_valid=0, rx_overrun=0.
REQ-038 With UART_RX_PARITY_EN and PARITY_MODE=1, frame 0x07 with parity bit 0 -> rx_parity_err=1; with parity bit 1 -> rx_parity_err=0.
